lead_one_pipe: RTL
==================

# lead_one_pipe

Two-stage pipelined leading-one isolator with a valid/ready handshake. It accepts a 32-bit word and produces a one-hot word that has only the most significant set bit of the input. All-zero input produces an all-zero output. It sits directly upstream of the one-hot-to-count encoder in the normalisation path, which turns the one-hot word into a 6-bit shift count.

## Interface
- WIDTH, 32, data width; only 32 is supported.
- GROUP, 8, group size for the stage-1 split; WIDTH/GROUP = 4 groups.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  32  word to scan.
- out_valid  output  1  out_onehot/out_zero valid.
- out_ready  input  1  downstream accepts this cycle.
- out_onehot  output  32  one-hot of the MSB set in in_data; all zero if in_data == 0.
- out_zero  output  1  high when the corresponding in_data was 0.
- zero_cnt  output  16  saturating count of zero words delivered (out_valid && out_ready && out_zero).

## Operation
- Stage 1 (S1), registered:
  - Splits in_data into 4 groups of 8 bits.
  - Selects the highest group with a nonzero OR: grp_idx[1:0] and grp_bits[7:0].
  - Sets s1_zero if all groups are zero; then grp_idx = 0 and grp_bits = 0.
- Stage 2 (S2), registered:
  - Isolates the MSB of grp_bits into onehot8.
  - Places it at bit offset grp_idx*8: out_onehot = onehot8 << (8*grp_idx).
  - Passes s1_zero through to out_zero.
- Each stage holds a valid bit: s1_v, s2_v (out_valid = s2_v).
- Stall logic:
  - s2_adv = !s2_v || out_ready.
  - s1_adv = !s1_v || s2_adv.
  - in_ready = s1_adv, which is combinational from out_ready. This gives full throughput with no bubble.
- Transfers:
  - S1 loads when in_valid && in_ready.
  - S2 loads S1 contents when s1_v && s2_adv.
  - A stage that is not advancing holds its data and valid bit unchanged.
- Output stability: while out_valid && !out_ready, out_onehot, out_zero and out_valid stay stable.
- zero_cnt increments by 1 on each accepted output with out_zero = 1 and saturates at 16'hFFFF.
- Input bit 31 set yields out_onehot = 32'h8000_0000. The block does no remapping; the downstream encoder owns how it handles bit 31.

## Timing
- Latency: 2 cycles from input acceptance to out_valid, assuming no backpressure.
- Throughput: 1 word per cycle while out_ready stays high.
- Reset (rst_n low at an edge):
  - s1_v = s2_v = 0; out_valid = 0, out_onehot = 0, out_zero = 0, zero_cnt = 0.
  - in_ready reads 1 during reset, but no transfer is recorded while rst_n is low.
- Reset mid-operation: in-flight words are discarded with no partial output. The first word accepted after rst_n rises appears 2 cycles later.
- Simultaneous accept and deliver: S2 unloads, S2 loads from S1 and S1 loads from the input, all on the same edge. No word is lost or duplicated.
- Full (s1_v = s2_v = 1, out_ready = 0): in_ready = 0; the upstream word must be held by the upstream handshake.
- Empty: out_valid = 0; out_onehot holds its last value, which is don't-care to consumers.
- zero_cnt at 16'hFFFF: stays at 16'hFFFF on further zero deliveries; it is cleared only by reset.

## Structure
- Package lead_one_pkg:
  - Constants WIDTH = 32, GROUP = 8, NGROUP = 4, GIDX_W = 2.
  - Typedef s1_t = {grp_idx, grp_bits, zero}.
- Sub-module msb_isolate8: combinational 8-bit MSB isolator, input [7:0] and output one-hot [7:0]; 0 gives 0.
  - Instantiated in S2.
  - S1 group selection uses an OR-reduction per group plus a 4-way priority mux.

## Test plan
- Reset, then in_data = 32'h0000_0001 with out_ready = 1 -> out_valid high 2 cycles after acceptance, out_onehot = 32'h0000_0001, out_zero = 0.
- Back-to-back stream: 32'h00F0_0000, 32'h8000_0001, 32'h0000_0000, 32'h0000_0300, with out_ready = 1 -> outputs 32'h0080_0000, 32'h8000_0000, 0 (out_zero = 1), 32'h0000_0200 on consecutive cycles; zero_cnt = 1.
- Backpressure: fill the pipe, hold out_ready = 0 for 5 cycles -> in_ready = 0 after 2 accepts, outputs stable, and on release 2 words emerge in order with none lost.
- Reset mid-stream: assert rst_n = 0 with both stages full -> next edge out_valid = 0, zero_cnt = 0; the next accepted word 32'h0001_0000 yields 32'h0001_0000 after 2 cycles.
- Saturation: deliver 65,537 zero words -> zero_cnt = 16'hFFFF.
- Random check: for random in_data, including 0, out_onehot equals a reference MSB isolation and $onehot0(out_onehot) holds on every output.

Source files
------------

// File: rtl/lead_one_pkg.sv
// Shared constants and the stage-1 payload type for the leading-one isolator.
package lead_one_pkg;

  localparam int WIDTH  = 32;
  localparam int GROUP  = 8;
  localparam int NGROUP = WIDTH / GROUP;
  localparam int GIDX_W = 2;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [GIDX_W-1:0] grp_idx;
    logic [GROUP-1:0]  grp_bits;
    logic              zero;
  } s1_t;

endpackage

// File: rtl/msb_isolate8.sv
// Combinational 8-bit MSB isolator: keeps only the highest set bit, 0 maps to 0.
module msb_isolate8 (
  input  logic [7:0] in_bits,
  output logic [7:0] onehot
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    onehot = 8'b0;
    for (int i = 0; i < 8; i++) begin
      if (in_bits[i]) onehot = 8'b1 << i;
    end
  end

endmodule

// File: rtl/lead_one_pipe.sv
// Two-stage leading-one isolator: S1 picks the top nonzero byte group,
// S2 isolates that group's MSB and places it back at the group's offset.
module lead_one_pipe
  import lead_one_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic             out_zero,
  output logic [CNT_W-1:0] zero_cnt
);

  s1_t              s1_q, s1_d, s1_new;
  logic             s1_v_q, s1_v_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] onehot_q, onehot_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;

  logic              s1_adv, s2_adv;
  logic [NGROUP-1:0] grp_or;
  logic [GROUP-1:0]  onehot8;

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv || !rst_n;

  always_comb begin
    for (int g = 0; g < NGROUP; g++) begin
      grp_or[g] = |in_data[g*GROUP +: GROUP];
    end
  end

  // Highest nonzero group wins; an all-zero word leaves index and bits at 0.
  always_comb begin
    s1_new = '0;
    s1_new.zero = 1'b0;
    if (grp_or[3]) begin
      s1_new.grp_idx  = 2'd3;
      s1_new.grp_bits = in_data[31:24];
    end else if (grp_or[2]) begin
      s1_new.grp_idx  = 2'd2;
      s1_new.grp_bits = in_data[23:16];
    end else if (grp_or[1]) begin
      s1_new.grp_idx  = 2'd1;
      s1_new.grp_bits = in_data[15:8];
    end else if (grp_or[0]) begin
      s1_new.grp_idx  = 2'd0;
      s1_new.grp_bits = in_data[7:0];
    end else begin
      s1_new.zero = 1'b1;
    end
  end

  msb_isolate8 u_isolate (
    .in_bits (s1_q.grp_bits),
    .onehot  (onehot8)
  );

  always_comb begin
    s1_d       = s1_q;
    s1_v_d     = s1_v_q;
    s2_v_d     = s2_v_q;
    onehot_d   = onehot_q;
    zero_d     = zero_q;
    zero_cnt_d = zero_cnt_q;

    if (s1_adv) begin
      s1_v_d = in_valid;
      if (in_valid) s1_d = s1_new;
    end

    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        onehot_d = {{(WIDTH-GROUP){1'b0}}, onehot8} << {s1_q.grp_idx, 3'b000};
        zero_d   = s1_q.zero;
      end
    end

    if (s2_v_q && out_ready && zero_q && (zero_cnt_q != {CNT_W{1'b1}})) begin
      zero_cnt_d = zero_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      onehot_q   <= '0;
      zero_q     <= 1'b0;
      zero_cnt_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_v_q     <= s1_v_d;
      s2_v_q     <= s2_v_d;
      onehot_q   <= onehot_d;
      zero_q     <= zero_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign out_valid  = s2_v_q;
  assign out_onehot = onehot_q;
  assign out_zero   = zero_q;
  assign zero_cnt   = zero_cnt_q;

endmodule
